if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline: holds the PC, issues requests to instruction memory,
//  and loads the IF/ID register (instr_decode, pc_decode) consumed by the decode stage.
//  Acts on the redirect targets (pc_branch, pc_jump, pcsrc, jump_decode) that decode resolves, and honours stall/flush.
//  At most one outstanding imem request; a skid buffer holds a response that arrives during a stall.
// PARAMETERS
//  WIDTH     32     datapath / address width
//  RESET_PC  32'h0  first fetch address after reset
//  NOP       32'h0  instruction loaded into IF/ID on flush (sll $0,$0,0)
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst            in   1      synchronous, active-high reset
//  stall_fetch    in   1      hazard unit: hold IF/ID and PC
//  flush_decode   in   1      clear IF/ID to NOP (ignored while stall_fetch=1)
//  pcsrc          in   1      taken branch resolved in decode
//  jump_decode    in   1      jump in decode
//  pc_branch      in   WIDTH  branch target
//  pc_jump        in   WIDTH  jump target
//  imem_req       out  1      request valid
//  imem_addr      out  WIDTH  request word address (byte address, [1:0]=0)
//  imem_ready     in   1      request accepted when imem_req & imem_ready
//  imem_rvalid    in   1      response valid, >=1 cycle after accept, in order
//  imem_rdata     in   WIDTH  response instruction
//  instr_decode   out  WIDTH  IF/ID instruction
//  pc_decode      out  WIDTH  IF/ID PC+4 of that instruction
//  valid_decode   out  1      IF/ID holds a real instruction
// BEHAVIOUR
//  Reset: pc_fetch=RESET_PC, instr_decode=NOP, pc_decode=0, valid_decode=0, skid empty, state=ISSUE.
//  Registers: pc_fetch (next request address), pc_req (address of outstanding request), skid_instr/skid_pc.
//  redirect = (pcsrc|jump_decode) & ~stall_fetch; target = pcsrc ? pc_branch : pc_jump (pcsrc wins if both).
//  States:
//   ISSUE: imem_req=1, imem_addr=pc_fetch. On accept: pc_req<=pc_fetch, pc_fetch<=pc_fetch+4, ->WAIT.
//          Redirect: pc_fetch<=target; if also accepted that cycle, ->DROP (wrong-path request).
//   WAIT : on imem_rvalid with no stall/redirect: IF/ID<={rdata, pc_req+4}, valid=1; imem_req=1 same cycle
//          (back-to-back, 1 instr/cycle at 1-cycle memory); accept ->WAIT, else ->ISSUE.
//          rvalid & stall_fetch: response -> skid, ->HOLD, imem_req=0.
//          redirect & rvalid: response discarded, pc_fetch<=target, ->ISSUE.
//          redirect & ~rvalid: pc_fetch<=target, ->DROP.
//   HOLD : imem_req=0. When stall_fetch=0: skid -> IF/ID, ->ISSUE; redirect same cycle: skid discarded,
//          IF/ID<=NOP, pc_fetch<=target, ->ISSUE.
//   DROP : imem_req=0; next imem_rvalid discarded, ->ISSUE. Further redirects update pc_fetch only.
//  IF/ID update priority: stall_fetch (hold all) > flush_decode or redirect (NOP, valid=0) > new instr.
//   If no instruction arrives and no stall, IF/ID loads NOP with valid_decode=0 (bubble).
//  stall_fetch does not block a request already issued; it only blocks new requests (ISSUE holds imem_req low).
//  pc_fetch wraps modulo 2^WIDTH; +4 arithmetic in WIDTH bits. Targets used as given (low 2 bits not checked).
//  rst mid-operation: any outstanding response arriving after reset is ignored (state=ISSUE waits for accept
//   before trusting rvalid; rvalid in ISSUE is dropped).
//  Latency: accept at cycle N, rvalid at N+1 -> instr_decode valid from N+2.
// TESTING
//  1 Reset, imem_ready=1, rvalid 1 cycle after accept, mem[i]=i -> addrs 0,4,8,...; instr_decode 0,1,2 on
//    consecutive cycles, pc_decode 4,8,12.
//  2 Stall 3 cycles while response for addr 8 in flight -> skid holds it; IF/ID frozen; on release
//    instr_decode=mem[8], pc_decode=12, next imem_addr=12.
//  3 pcsrc=1, pc_branch=0x40 while WAIT for addr 0x10 -> response for 0x10 dropped, next imem_addr=0x40,
//    IF/ID=NOP/valid=0 for the bubble cycle.
//  4 pcsrc=1 and jump_decode=1 same cycle, pc_branch=0x80, pc_jump=0xC0 -> next fetch 0x80.
//  5 imem_ready low 4 cycles -> imem_req held at same addr, valid_decode=0 bubbles, no address skipped.
//  6 rst asserted with request outstanding, stale rvalid next cycle -> ignored; first fetch addr=RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a single-outstanding imem request channel and
// loads the IF/ID register, with a one-entry skid buffer for responses that land during a stall.
module if_stage #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP      = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_fetch,
  input  logic             flush_decode,
  input  logic             pcsrc,
  input  logic             jump_decode,
  input  logic [WIDTH-1:0] pc_branch,
  input  logic [WIDTH-1:0] pc_jump,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr_decode,
  output logic [WIDTH-1:0] pc_decode,
  output logic             valid_decode
);

  typedef enum logic [1:0] {StIssue, StWait, StHold, StDrop} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_fetch_q, pc_req_q;
  logic [WIDTH-1:0] skid_instr_q, skid_pc_q;
  logic [WIDTH-1:0] instr_q, pc_dec_q;
  logic             valid_q;

  logic             redirect, accept;
  logic [WIDTH-1:0] target, pc_fetch_inc, pc_req_inc;

  assign redirect     = (pcsrc | jump_decode) & ~stall_fetch;
  assign target       = pcsrc ? pc_branch : pc_jump;
  assign pc_fetch_inc = pc_fetch_q + WIDTH'(4);
  assign pc_req_inc   = pc_req_q + WIDTH'(4);

  // WAIT re-issues in the same cycle a response is consumed to sustain one fetch per cycle.
  always_comb begin
    imem_req = 1'b0;
    unique case (state_q)
      StIssue: imem_req = ~stall_fetch;
      StWait:  imem_req = imem_rvalid & ~stall_fetch & ~redirect;
      default: imem_req = 1'b0;
    endcase
  end

  assign accept    = imem_req & imem_ready;
  assign imem_addr = pc_fetch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIssue;
      pc_fetch_q   <= RESET_PC;
      pc_req_q     <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      instr_q      <= NOP;
      pc_dec_q     <= '0;
      valid_q      <= 1'b0;
    end else begin
      // Bubble unless stalled; the cases below override with a real instruction.
      if (!stall_fetch) begin
        instr_q  <= NOP;
        pc_dec_q <= '0;
        valid_q  <= 1'b0;
      end
      unique case (state_q)
        StIssue: begin
          if (accept) begin
            pc_req_q <= pc_fetch_q;
            if (redirect) begin
              pc_fetch_q <= target;
              state_q    <= StDrop;
            end else begin
              pc_fetch_q <= pc_fetch_inc;
              state_q    <= StWait;
            end
          end else if (redirect) begin
            pc_fetch_q <= target;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            if (stall_fetch) begin
              skid_instr_q <= imem_rdata;
              skid_pc_q    <= pc_req_inc;
              state_q      <= StHold;
            end else if (redirect) begin
              pc_fetch_q <= target;
              state_q    <= StIssue;
            end else begin
              if (!flush_decode) begin
                instr_q  <= imem_rdata;
                pc_dec_q <= pc_req_inc;
                valid_q  <= 1'b1;
              end
              if (accept) begin
                pc_req_q   <= pc_fetch_q;
                pc_fetch_q <= pc_fetch_inc;
              end else begin
                state_q <= StIssue;
              end
            end
          end else if (redirect) begin
            pc_fetch_q <= target;
            state_q    <= StDrop;
          end
        end
        StHold: begin
          if (!stall_fetch) begin
            state_q <= StIssue;
            if (redirect) begin
              pc_fetch_q <= target;
            end else if (!flush_decode) begin
              instr_q  <= skid_instr_q;
              pc_dec_q <= skid_pc_q;
              valid_q  <= 1'b1;
            end
          end
        end
        StDrop: begin
          if (redirect) pc_fetch_q <= target;
          if (imem_rvalid) state_q <= StIssue;
        end
        default: state_q <= StIssue;
      endcase
    end
  end

  assign instr_decode = instr_q;
  assign pc_decode    = pc_dec_q;
  assign valid_decode = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a one-cycle-latency memory returning word index (addr>>2) as data.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall_fetch, flush_decode, pcsrc, jump_decode;
  logic [31:0] pc_branch, pc_jump;
  logic        imem_req, imem_ready, imem_rvalid, valid_decode;
  logic [31:0] imem_addr, imem_rdata, instr_decode, pc_decode;

  logic        stale;
  int          tests_run = 0;
  int          tests_failed = 0;

  if_stage #(.WIDTH(32), .RESET_PC(32'h0), .NOP(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_fetch  (stall_fetch),
    .flush_decode (flush_decode),
    .pcsrc        (pcsrc),
    .jump_decode  (jump_decode),
    .pc_branch    (pc_branch),
    .pc_jump      (pc_jump),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_decode (instr_decode),
    .pc_decode    (pc_decode),
    .valid_decode (valid_decode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: capture the handshake, then present the memory response one cycle later.
  task automatic step();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = imem_req & imem_ready & ~rst;
    a   = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = acc | stale;
    imem_rdata  = a >> 2;
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_fetch = 1'b0; flush_decode = 1'b0; pcsrc = 1'b0; jump_decode = 1'b0;
    pc_branch = '0; pc_jump = '0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    stale = 1'b0;

    step(); step();
    check("rst_valid", {31'b0, valid_decode}, 32'd0);
    check("rst_instr", instr_decode, 32'h0);
    check("rst_pcdec", pc_decode, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'd1);
    rst = 1'b0;

    // Back-to-back fetch
    step();
    check("t1_addr4", imem_addr, 32'h4);
    check("t1_bubble", {31'b0, valid_decode}, 32'd0);
    step();
    check("t1_instr0", instr_decode, 32'd0);
    check("t1_pc4", pc_decode, 32'h4);
    check("t1_valid", {31'b0, valid_decode}, 32'd1);
    step();
    check("t1_instr1", instr_decode, 32'd1);
    check("t1_pc8", pc_decode, 32'h8);
    check("t1_addr12", imem_addr, 32'hC);

    // Stall while the response for address 8 is in flight
    stall_fetch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_frozen_instr", instr_decode, 32'd1);
      check("t2_frozen_pc", pc_decode, 32'h8);
      check("t2_noreq", {31'b0, imem_req}, 32'd0);
    end
    stall_fetch = 1'b0;
    step();
    check("t2_skid_instr", instr_decode, 32'd2);
    check("t2_skid_pc", pc_decode, 32'hC);
    check("t2_skid_valid", {31'b0, valid_decode}, 32'd1);
    check("t2_next_addr", imem_addr, 32'hC);

    // Branch redirect while waiting on 0x10
    step();
    check("t3_bubble", {31'b0, valid_decode}, 32'd0);
    step();
    check("t3_instr3", instr_decode, 32'd3);
    pcsrc = 1'b1; pc_branch = 32'h40;
    step();
    pcsrc = 1'b0;
    check("t3_nop_valid", {31'b0, valid_decode}, 32'd0);
    check("t3_nop_instr", instr_decode, 32'h0);
    check("t3_addr40", imem_addr, 32'h40);
    step(); step();
    check("t3_instr_tgt", instr_decode, 32'h10);
    check("t3_pc_tgt", pc_decode, 32'h44);

    // Branch beats jump
    pcsrc = 1'b1; jump_decode = 1'b1; pc_branch = 32'h80; pc_jump = 32'hC0;
    step();
    pcsrc = 1'b0; jump_decode = 1'b0;
    check("t4_branch_wins", imem_addr, 32'h80);

    // Memory not ready: request held, bubbles
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_req_held", {31'b0, imem_req}, 32'd1);
      check("t5_addr_held", imem_addr, 32'h80);
      check("t5_bubble", {31'b0, valid_decode}, 32'd0);
    end
    imem_ready = 1'b1;
    step(); step();
    check("t5_instr", instr_decode, 32'h20);
    check("t5_pc", pc_decode, 32'h84);
    check("t5_next_addr", imem_addr, 32'h88);

    // Reset with a request outstanding, stale response afterwards
    rst = 1'b1; stale = 1'b1;
    step();
    rst = 1'b0; stale = 1'b0;
    check("t6_reset_addr", imem_addr, 32'h0);
    step();
    check("t6_stale_ignored", {31'b0, valid_decode}, 32'd0);
    step();
    check("t6_instr0", instr_decode, 32'd0);
    check("t6_pc4", pc_decode, 32'h4);
    check("t6_valid", {31'b0, valid_decode}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
